data_mem_hs: RTL



---
 rtl/data_mem_hs.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_hs.sv
// Request/response data memory for RV32I loads/stores; response WAIT_STATES+1 cycles after acceptance.
// One access in flight: req_ready only in IDLE, response held until resp_ready.
module data_mem_hs #(
  parameter int                    MEM_SIZE    = 64,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int                    IDX_W     = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_SIZE * 4);
  localparam logic [3:0]            CNT_INIT  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit                    NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [MEM_SIZE];
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic                  r_busy;
  logic [31:0]           r_resp_rdata;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_we;
  logic [2:0]            w_funct3;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_wdata;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_err;
  logic [31:0]           w_rdata;
  logic [3:0]            w_be;
  logic [31:0]           w_wd;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid && r_req_ready;
  assign w_commit = (NO_WAIT && w_idle && w_accept) || (r_state == WAIT && r_cnt == 4'd0);

  // With no wait states the commit edge is the acceptance edge, so decode straight from the inputs.
  assign w_we     = w_idle ? req_we     : r_we;
  assign w_funct3 = w_idle ? req_funct3 : r_funct3;
  assign w_addr   = w_idle ? req_addr   : r_addr;
  assign w_wdata  = w_idle ? req_wdata  : r_wdata;

  assign w_off  = w_addr - BASE_ADDR;
  assign w_idx  = w_off[IDX_W+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_err   = (w_off >= MEM_BYTES);
    w_rdata = '0;
    w_be    = '0;
    w_wd    = '0;
    w_byte  = '0;
    w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    case (w_funct3[1:0])
      2'b01:   if (w_addr[0]) w_err = 1'b1;
      2'b10:   if (w_addr[1:0] != 2'b00) w_err = 1'b1;
      2'b11:   w_err = 1'b1;
      default: ;
    endcase
    if (w_we && w_funct3[2]) w_err = 1'b1;
    if (!w_we && w_funct3 == 3'b110) w_err = 1'b1;
    if (!w_err) begin
      if (w_we) begin
        case (w_funct3[1:0])
          2'b00:   begin w_be = 4'b0001 << w_addr[1:0];      w_wd = {4{w_wdata[7:0]}};  end
          2'b01:   begin w_be = 4'b0011 << {w_addr[1], 1'b0}; w_wd = {2{w_wdata[15:0]}}; end
          default: begin w_be = 4'b1111;                      w_wd = w_wdata;            end
        endcase
      end else begin
        case (w_funct3)
          3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
          3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
          3'b010:  w_rdata = w_word;
          3'b100:  w_rdata = {24'd0, w_byte};
          3'b101:  w_rdata = {16'd0, w_half};
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_we        <= req_we;
          r_funct3    <= req_funct3;
          r_addr      <= req_addr;
          r_wdata     <= req_wdata;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b1;
          if (NO_WAIT) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
            r_resp_err   <= w_err;
          end else begin
            r_state <= WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        WAIT: if (r_cnt == 4'd0) begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_rdata;
          r_resp_err   <= w_err;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: if (resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Reset wins over a same-edge commit so a dropped store never lands.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule
